// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the 1RW SRAM controller.
// State encoding for the zero-fill / service FSM.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 52;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_RESP_DEPTH = 3;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

endpackage

// File: rtl/sram_ctrl_resp_fifo.sv
// Read-response queue for the SRAM controller.
// Exports its fill count so the parent can meter request credit.
module sram_ctrl_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_RESP_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push &&
                   ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Valid/ready front end for a single-port synchronous SRAM macro.
// Zero-fills the array after reset, then meters reads by queue credit.
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(RESP_DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] init_cnt;
  logic            rd_pend;
  logic            req_fire;
  logic            in_init;
  logic [CW-1:0]   q_count;
  logic [CW:0]     used;

  assign in_init   = (state == S_INIT);
  assign init_done = !in_init;

  // A read in flight already owns a queue slot.
  assign used      = {1'b0, q_count} + {{CW{1'b0}}, rd_pend};
  assign req_ready = !in_init && (used < CREDITS);
  assign req_fire  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_ZERO ? S_INIT : S_READY;
      init_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= req_fire && !req_write;
      if (in_init) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == LAST) state <= S_READY;
      end
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_write = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (1'b1)
      in_init: begin
        sram_en    = 1'b1;
        sram_write = 1'b1;
        sram_addr  = init_cnt[ADDR_W-1:0];
      end
      req_fire: begin
        sram_en    = 1'b1;
        sram_write = req_write;
        sram_addr  = req_addr;
        sram_wdata = req_data;
      end
      default: ;
    endcase
  end

  sram_ctrl_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (sram_rdata),
    .pop       (resp_ready),
    .count     (q_count),
    .head      (resp_data)
  );

  assign resp_valid = (q_count != '0);

endmodule
